// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Encodings follow the RV64 load/store funct3 field.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   // Access width in bytes; low two funct3 bits carry the size.
   function automatic logic [3:0] size_bytes(input logic [2:0] f3);
      logic [3:0] n;
      case (f3[1:0])
         2'b00:   n = 4'd1;
         2'b01:   n = 4'd2;
         2'b10:   n = 4'd4;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

   // True when the byte offset is not a multiple of the access size.
   function automatic logic misaligned(input logic [2:0] f3,
                                       input logic [2:0] off);
      logic m;
      case (f3[1:0])
         2'b01:   m = off[0];
         2'b10:   m = |off[1:0];
         2'b11:   m = |off;
         default: m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: load extract/extend and store merge
// for sub-doubleword accesses on a 64-bit memory word.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  i_f3,
   input  logic [2:0]  i_off,
   input  logic [63:0] i_word,
   input  logic [63:0] i_wdata,
   output logic [63:0] o_load,
   output logic [63:0] o_merge
);

   logic [3:0]  w_size;
   logic [63:0] w_shift;
   logic [63:0] w_ins;
   logic [63:0] w_mask;
   logic [7:0]  w_lenmask;
   logic [7:0]  w_bmask;

   assign w_size    = size_bytes(i_f3);
   assign w_shift   = i_word >> {i_off, 3'b000};
   assign w_ins     = i_wdata << {i_off, 3'b000};
   assign w_lenmask = 8'((9'd1 << w_size) - 9'd1);
   assign w_bmask   = w_lenmask << i_off;

   // Pick the addressed field and sign/zero extend it.
   always_comb begin
      o_load = '0;
      case (i_f3)
         F3_B:    o_load = {{56{w_shift[7]}}, w_shift[7:0]};
         F3_H:    o_load = {{48{w_shift[15]}}, w_shift[15:0]};
         F3_W:    o_load = {{32{w_shift[31]}}, w_shift[31:0]};
         F3_D:    o_load = w_shift;
         F3_BU:   o_load = {56'd0, w_shift[7:0]};
         F3_HU:   o_load = {48'd0, w_shift[15:0]};
         F3_WU:   o_load = {32'd0, w_shift[31:0]};
         default: o_load = '0;
      endcase
   end

   // Expand the per-byte enable into a bit mask.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < 8; i++) begin
         w_mask[i*8 +: 8] = {8{w_bmask[i]}};
      end
   end

   assign o_merge = (i_word & ~w_mask) | (w_ins & w_mask);

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, sub-doubleword
// stores done as read-modify-write on the 64-bit memory port.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [63:0] mem_address,
   output logic [63:0] mem_write_data,
   input  logic [63:0] mem_read_data
);

   state_t      r_state;
   logic        r_we;
   logic [2:0]  r_f3;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic [63:0] r_word;
   logic [63:0] r_rdata;
   logic        r_err;

   logic        w_err;
   logic        w_bad_f3;
   logic        w_range;
   logic [63:0] w_lane_word;
   logic [63:0] w_load;
   logic [63:0] w_merge;

   assign w_bad_f3 = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
   assign w_range  = req_addr[63:3] >= 61'(MEM_WORDS);
   assign w_err    = w_bad_f3 | w_range
                   | misaligned(req_funct3, req_addr[2:0]);

   // RD extracts from the live memory word; WR merges into the saved one.
   assign w_lane_word = (r_state == RD) ? mem_read_data : r_word;

   lsu_byte_lane u_lane (
      .i_f3    (r_f3),
      .i_off   (r_addr[2:0]),
      .i_word  (w_lane_word),
      .i_wdata (r_wdata),
      .o_load  (w_load),
      .o_merge (w_merge)
   );

   assign req_ready      = (r_state == IDLE);
   assign resp_valid     = (r_state == RESP);
   assign resp_err       = (r_state == RESP) & r_err;
   assign resp_rdata     = r_rdata;
   assign mem_read       = (r_state == RD);
   assign mem_write      = (r_state == WR);
   assign mem_address    = {r_addr[63:3], 3'b000};
   assign mem_write_data = mem_write ? w_merge : '0;

   // Request sequencer: accept, optional read, optional write, respond.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_we    <= 1'b0;
         r_f3    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_word  <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_we    <= req_we;
                  r_f3    <= req_funct3;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  if (w_err) begin
                     r_err   <= 1'b1;
                     r_rdata <= '0;
                     r_state <= RESP;
                  end else if (req_we && req_funct3 == F3_D) begin
                     r_state <= WR;
                  end else begin
                     r_state <= RD;
                  end
               end
            end
            RD: begin
               if (r_we) begin
                  r_word  <= mem_read_data;
                  r_state <= WR;
               end else begin
                  r_rdata <= w_load;
                  r_err   <= 1'b0;
                  r_state <= RESP;
               end
            end
            WR: begin
               r_rdata <= '0;
               r_err   <= 1'b0;
               r_state <= RESP;
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: negedge memory, byte-level
// reference model, per-cycle compare and directed vectors.
module tb_load_store_unit;

   localparam int MEM_WORDS = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [63:0] req_addr = 64'd0;
   logic [63:0] req_wdata = 64'd0;
   logic        req_ready;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_address;
   logic [63:0] mem_write_data;
   logic [63:0] mem_read_data = 64'd0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   logic [63:0] phys [MEM_WORDS];
   logic [7:0]  ref_b [MEM_WORDS*8];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int acc_cyc = 0;
   int resp_cnt = 0;

   bit          pend = 1'b0;
   logic        p_we;
   logic [2:0]  p_f3;
   logic [63:0] p_addr;
   logic [63:0] p_wdata;
   int          p_cyc;
   logic [63:0] last_rdata = 64'd0;
   logic        last_err = 1'b0;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit m_err(input logic we, input logic [2:0] f3,
                                input logic [63:0] a);
      if (we && f3[2]) return 1'b1;
      if (!we && f3 == 3'b111) return 1'b1;
      if ((a >> 3) >= 64'(MEM_WORDS)) return 1'b1;
      if ((a % 64'(nbytes(f3))) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_lat(input logic we, input logic [2:0] f3,
                                input logic [63:0] a);
      if (m_err(we, f3, a)) return 1;
      if (!we || f3 == 3'b011) return 2;
      return 3;
   endfunction

   function automatic logic [63:0] m_load(input logic [63:0] a,
                                          input logic [2:0] f3);
      logic [63:0] v;
      int n;
      int ai;
      n  = nbytes(f3);
      ai = int'(a);
      v  = '0;
      for (int i = 0; i < n; i++) v = v | (64'(ref_b[ai+i]) << (8*i));
      if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
      return v;
   endfunction

   function automatic logic [63:0] m_store_word(input logic [63:0] a,
                                                input logic [2:0] f3,
                                                input logic [63:0] wd);
      logic [63:0] w;
      int n;
      int ai;
      int base;
      n    = nbytes(f3);
      ai   = int'(a);
      base = ai & ~7;
      w    = '0;
      for (int k = 0; k < 8; k++) begin
         if (base + k >= ai && base + k < ai + n)
            w[8*k +: 8] = wd[8*(base+k-ai) +: 8];
         else
            w[8*k +: 8] = ref_b[base+k];
      end
      return w;
   endfunction

   // Physical memory: samples and updates on the falling edge.
   always @(negedge clk) begin
      if (mem_write) phys[mem_address[8:3]] = mem_write_data;
      if (mem_read)  mem_read_data = phys[mem_address[8:3]];
   end

   // Acceptance monitor.
   always @(posedge clk) begin
      cyc++;
      if (rst_n && req_valid && req_ready) begin
         chk("accept_when_idle", 64'(pend), 64'd0);
         acc_cnt++;
         acc_cyc = cyc;
         pend    = 1'b1;
         p_we    = req_we;
         p_f3    = req_funct3;
         p_addr  = req_addr;
         p_wdata = req_wdata;
         p_cyc   = cyc;
      end
   end

   always @(negedge rst_n) pend = 1'b0;

   // Per-cycle compare against the reference schedule and data.
   always @(negedge clk) begin
      int d;
      int lat;
      bit e;
      bit erd;
      bit ewr;
      bit erv;
      logic [63:0] sw;
      if (rst_n) begin
         if (!pend) begin
            chk("idle_ctl", {60'd0, mem_read, mem_write, resp_valid,
                req_ready}, 64'h1);
         end else begin
            d   = cyc - p_cyc;
            lat = m_lat(p_we, p_f3, p_addr);
            e   = m_err(p_we, p_f3, p_addr);
            erd = !e && d == 0 && !(p_we && p_f3 == 3'b011);
            ewr = !e && p_we && ((p_f3 == 3'b011 && d == 0) ||
                                 (p_f3 != 3'b011 && d == 1));
            erv = (d == lat - 1);
            chk("busy_ctl", {60'd0, mem_read, mem_write, resp_valid,
                req_ready}, {60'd0, erd, ewr, erv, 1'b0});
            if (mem_read || mem_write)
               chk("mem_address", mem_address, {p_addr[63:3], 3'b000});
            sw = '0;
            if (!e && p_we) sw = m_store_word(p_addr, p_f3, p_wdata);
            if (ewr && mem_write)
               chk("mem_write_data", mem_write_data, sw);
            if (resp_valid) begin
               chk("resp_err", 64'(resp_err), 64'(e));
               chk("resp_rdata", resp_rdata,
                   (e || p_we) ? 64'd0 : m_load(p_addr, p_f3));
               if (!e && p_we) begin
                  for (int k = 0; k < 8; k++)
                     ref_b[(int'(p_addr) & ~7) + k] = sw[8*k +: 8];
               end
               resp_cnt++;
               last_rdata = resp_rdata;
               last_err   = resp_err;
               pend       = 1'b0;
            end else if (d >= lat + 4) begin
               chk("resp_timeout", 64'd0, 64'd1);
               pend = 1'b0;
            end
         end
      end
   end

   task automatic do_req(input logic we, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd,
                         output logic [63:0] rd, output logic er);
      int n0;
      int a0;
      n0 = resp_cnt;
      a0 = acc_cnt;
      @(posedge clk);
      #2;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      @(posedge clk);
      #2;
      req_valid = 1'b0;
      chk("accepted", 64'(acc_cnt - a0), 64'd1);
      for (int i = 0; i < 10 && resp_cnt == n0; i++) @(posedge clk);
      if (resp_cnt == n0) chk("resp_wait", 64'd0, 64'd1);
      rd = last_rdata;
      er = last_err;
   endtask

   task automatic req_chk(input string nm, input logic we,
                          input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] xrd,
                          input logic xer);
      logic [63:0] rd;
      logic er;
      do_req(we, f3, a, wd, rd, er);
      chk({nm, "_rdata"}, rd, xrd);
      chk({nm, "_err"}, 64'(er), 64'(xer));
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int a0;
      int r0;
      int c1;
      int c2;
      int k;
      for (int i = 0; i < MEM_WORDS; i++) begin
         phys[i] = {32'(i) * 32'h9E3779B9, 32'h5A5A0000 + 32'(i)};
         for (int b = 0; b < 8; b++) ref_b[i*8+b] = phys[i][8*b +: 8];
      end

      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_err", 64'(resp_err), 64'd0);
      chk("rst_resp_rdata", resp_rdata, 64'd0);
      chk("rst_mem_ctl", {62'd0, mem_read, mem_write}, 64'd0);
      chk("rst_mem_address", mem_address, 64'd0);
      chk("rst_mem_wdata", mem_write_data, 64'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      req_chk("sd10", 1, 3'b011, 64'h10, 64'h1122334455667788, 64'd0, 0);
      req_chk("ld10", 0, 3'b011, 64'h10, 64'd0,
              64'h1122334455667788, 0);

      req_chk("sd10b", 1, 3'b011, 64'h10, 64'h80FF, 64'd0, 0);
      req_chk("lb10", 0, 3'b000, 64'h10, 64'd0, 64'hFFFFFFFFFFFFFFFF, 0);
      req_chk("lbu11", 0, 3'b100, 64'h11, 64'd0, 64'h80, 0);
      req_chk("lh10", 0, 3'b001, 64'h10, 64'd0, 64'hFFFFFFFFFFFF80FF, 0);
      req_chk("lhu10", 0, 3'b101, 64'h10, 64'd0, 64'h80FF, 0);

      req_chk("sd18", 1, 3'b011, 64'h18, 64'hAAAAAAAAAAAAAAAA, 64'd0, 0);
      req_chk("sb1b", 1, 3'b000, 64'h1B, 64'h55, 64'd0, 0);
      req_chk("ld18", 0, 3'b011, 64'h18, 64'd0, 64'hAAAAAAAA55AAAAAA, 0);

      req_chk("sw20", 1, 3'b010, 64'h20, 64'h80000001, 64'd0, 0);
      req_chk("lw20", 0, 3'b010, 64'h20, 64'd0, 64'hFFFFFFFF80000001, 0);
      req_chk("lwu20", 0, 3'b110, 64'h20, 64'd0, 64'h80000001, 0);

      req_chk("err_sw22", 1, 3'b010, 64'h22, 64'h1234, 64'd0, 1);
      req_chk("err_lh01", 0, 3'b001, 64'h01, 64'd0, 64'd0, 1);
      req_chk("err_ld0c", 0, 3'b011, 64'h0C, 64'd0, 64'd0, 1);
      req_chk("err_f3_7", 0, 3'b111, 64'h10, 64'd0, 64'd0, 1);
      req_chk("err_ld200", 0, 3'b011, 64'h200, 64'd0, 64'd0, 1);
      req_chk("err_sbu", 1, 3'b100, 64'h10, 64'h77, 64'd0, 1);

      req_chk("sd28", 1, 3'b011, 64'h28, 64'h0123456789ABCDEF, 64'd0, 0);
      @(posedge clk);
      #2;
      req_we     = 1'b1;
      req_funct3 = 3'b001;
      req_addr   = 64'h28;
      req_wdata  = 64'hBEEF;
      req_valid  = 1'b1;
      @(posedge clk);
      #2;
      req_valid = 1'b0;
      k = 0;
      while (!mem_write && k < 6) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("sh_wr_seen", 64'(mem_write), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_write", 64'(mem_write), 64'd0);
      chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
      chk("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      req_chk("ld28", 0, 3'b011, 64'h28, 64'd0, 64'h0123456789ABCDEF, 0);

      a0 = acc_cnt;
      r0 = resp_cnt;
      c1 = 0;
      c2 = 0;
      @(posedge clk);
      #2;
      req_we     = 1'b0;
      req_funct3 = 3'b011;
      req_addr   = 64'h10;
      req_valid  = 1'b1;
      k = 0;
      while (acc_cnt < a0 + 1 && k < 20) begin
         @(posedge clk);
         #2;
         k++;
      end
      c1 = acc_cyc;
      k = 0;
      while (acc_cnt < a0 + 2 && k < 20) begin
         @(posedge clk);
         #2;
         k++;
      end
      c2 = acc_cyc;
      req_valid = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      chk("hold_accepts", 64'(acc_cnt - a0), 64'd2);
      chk("hold_resp_pulses", 64'(resp_cnt - r0), 64'd2);
      chk("hold_accept_gap", 64'(c2 - c1), 64'd3);
      chk("hold_rdata", last_rdata, 64'h80FF);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
